// File: rtl/mem_stage_pkg.sv
// Shared encodings and lane helpers for the memory-access stage.
// MEM_MISALIGN_TRAP_EN (optional) makes use of is_misaligned().
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_ALL     = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Size code 11 is handled as a word everywhere via the default arms.
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = BE_BYTE0 << addr_lo;
      SZ_HALF: be = addr_lo[1] ? BE_HI_HALF : BE_LO_HALF;
      default: be = BE_ALL;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] data;
    case (size)
      SZ_BYTE: data = {4{wd[7:0]}};
      SZ_HALF: data = {2{wd[15:0]}};
      default: data = wd;
    endcase
    return data;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load formatter: picks the byte/half lane out of a read word
// and sign- or zero-extends it to 32 bits.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] load_value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = rdata[{addr_lo, 3'b000} +: 8];
    half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_value = rdata;
    case (size)
      SZ_BYTE: load_value = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_value = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default: load_value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage access unit: turns load/store requests into a req/ack memory
// transaction, stalls the pipeline until it completes or times out.
// Optional macro MEM_MISALIGN_TRAP_EN adds misalignM and traps misaligned accesses.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memReadM,
  input  logic        memWriteM,
  input  logic [1:0]  sizeM,
  input  logic        unsignedM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] writeDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] readDataM,
  output logic        stallM,
  output logic        busErrM
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalignM
`endif
);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              access;
  logic              is_load;
  logic [1:0]        size_q;
  logic [1:0]        addr_lo_q;
  logic              unsigned_q;
  logic [31:0]       load_value;

  assign access = memReadM | memWriteM;
  assign stallM = access && (state != DONE);

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = is_misaligned(sizeM, ALUOutM[1:0]);
`endif

  // Formatting uses the request captured at issue, not the live EX/MEM fields.
  mem_load_align u_load_align (
    .rdata       (dmem_rdata),
    .addr_lo     (addr_lo_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .load_value  (load_value)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      readDataM  <= '0;
      busErrM    <= 1'b0;
      is_load    <= 1'b0;
      size_q     <= '0;
      addr_lo_q  <= '0;
      unsigned_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalignM  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
`ifdef MEM_MISALIGN_TRAP_EN
            misalignM <= misaligned;
            if (misaligned) begin
              readDataM <= '0;
              state     <= DONE;
            end else
`endif
            begin
              // A simultaneous read and write is treated purely as a store.
              dmem_req   <= 1'b1;
              dmem_we    <= memWriteM;
              dmem_addr  <= {ALUOutM[31:2], 2'b00};
              dmem_be    <= store_be(sizeM, ALUOutM[1:0]);
              dmem_wdata <= store_wdata(sizeM, writeDataM);
              is_load    <= ~memWriteM;
              size_q     <= sizeM;
              addr_lo_q  <= ALUOutM[1:0];
              unsigned_q <= unsignedM;
              wait_cnt   <= '0;
              busErrM    <= 1'b0;
              state      <= BUSY;
            end
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (is_load) readDataM <= load_value;
            state <= DONE;
          end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
            dmem_req  <= 1'b0;
            busErrM   <= 1'b1;
            readDataM <= '0;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed, table-driven bench for mem_access_stage (default MAX_WAIT=16);
// adds a trap sequence when MEM_MISALIGN_TRAP_EN is defined.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        memReadM, memWriteM, unsignedM;
  logic [1:0]  sizeM;
  logic [31:0] ALUOutM, writeDataM;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, readDataM;
  logic [3:0]  dmem_be;
  logic        stallM, busErrM;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalignM;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk        (clk),
    .reset      (reset),
    .memReadM   (memReadM),
    .memWriteM  (memWriteM),
    .sizeM      (sizeM),
    .unsignedM  (unsignedM),
    .ALUOutM    (ALUOutM),
    .writeDataM (writeDataM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .readDataM  (readDataM),
    .stallM     (stallM),
    .busErrM    (busErrM)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalignM  (misalignM)
`endif
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_we;
    logic [31:0] e_read;
    logic        misal;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; ends one idle cycle after DONE.
  task automatic applyStimulus(input vec_t v);
    int stall_cnt = 0;
    int req_cnt   = 0;
    memReadM   = v.rd;
    memWriteM  = v.wr;
    sizeM      = v.size;
    unsignedM  = v.uns;
    ALUOutM    = v.addr;
    writeDataM = v.wd;
    dmem_rdata = v.rdata;
    dmem_ack   = 1'b0;
    #1;
    if (stallM) stall_cnt++;
    for (int k = 1; k <= v.delay; k++) begin
      @(negedge clk);
      if (stallM) stall_cnt++;
      if (dmem_req) req_cnt++;
      if (k == 1) begin
        checkOutput("addr", dmem_addr, v.e_addr);
        checkOutput("be", {28'd0, dmem_be}, {28'd0, v.e_be});
        checkOutput("wdata", dmem_wdata, v.e_wdata);
        checkOutput("we", {31'd0, dmem_we}, {31'd0, v.e_we});
      end
      if (k == v.delay) dmem_ack = 1'b1;
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    checkOutput("done_stall", {31'd0, stallM}, 32'd0);
    checkOutput("done_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("done_buserr", {31'd0, busErrM}, 32'd0);
    checkOutput("readData", readDataM, v.e_read);
    checkOutput("stall_cycles", stall_cnt, 1 + v.delay);
    checkOutput("req_cycles", req_cnt, v.delay);
    memReadM  = 1'b0;
    memWriteM = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int  req_cnt;
    bit  finished;
    reset = 1'b1;
    memReadM = 0; memWriteM = 0; sizeM = 0; unsignedM = 0;
    ALUOutM = 0; writeDataM = 0; dmem_ack = 0; dmem_rdata = 0;

    //          rd wr size   uns addr        wd            rdata         dly e_addr      e_be     e_wdata       we e_read        mis
    vecs[0]  = '{1, 0, 2'b10, 0, 32'h100, 32'h0,        32'hDEADBEEF, 2, 32'h100, 4'b1111, 32'h0,        0, 32'hDEADBEEF, 0};
    vecs[1]  = '{1, 0, 2'b00, 0, 32'h103, 32'h0,        32'h80000000, 1, 32'h100, 4'b1000, 32'h0,        0, 32'hFFFFFF80, 0};
    vecs[2]  = '{1, 0, 2'b00, 1, 32'h103, 32'h0,        32'h80000000, 1, 32'h100, 4'b1000, 32'h0,        0, 32'h00000080, 0};
    vecs[3]  = '{0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 32'h0,        1, 32'h200, 4'b1100, 32'hABCDABCD, 1, 32'h00000080, 0};
    vecs[4]  = '{1, 0, 2'b01, 0, 32'h102, 32'h0,        32'h80011234, 1, 32'h100, 4'b1100, 32'h0,        0, 32'hFFFF8001, 0};
    vecs[5]  = '{1, 0, 2'b00, 1, 32'h101, 32'h0,        32'h123456F0, 2, 32'h100, 4'b0010, 32'h0,        0, 32'h00000056, 0};
    vecs[6]  = '{0, 1, 2'b00, 0, 32'h301, 32'h123456A5, 32'h0,        1, 32'h300, 4'b0010, 32'hA5A5A5A5, 1, 32'h00000056, 0};
    vecs[7]  = '{0, 1, 2'b10, 0, 32'h400, 32'hCAFEF00D, 32'h0,        1, 32'h400, 4'b1111, 32'hCAFEF00D, 1, 32'h00000056, 0};
    vecs[8]  = '{1, 1, 2'b10, 0, 32'h500, 32'h11223344, 32'hFFFFFFFF, 1, 32'h500, 4'b1111, 32'h11223344, 1, 32'h00000056, 0};
    vecs[9]  = '{1, 0, 2'b11, 0, 32'h600, 32'h0,        32'h89ABCDEF, 1, 32'h600, 4'b1111, 32'h0,        0, 32'h89ABCDEF, 0};
    vecs[10] = '{1, 0, 2'b01, 0, 32'h103, 32'h0,        32'h7FFF0000, 1, 32'h100, 4'b1100, 32'h0,        0, 32'h00007FFF, 1};
    vecs[11] = '{1, 0, 2'b01, 1, 32'h100, 32'h0,        32'h00008765, 3, 32'h100, 4'b0011, 32'h0,        0, 32'h00008765, 0};

    repeat (2) @(negedge clk);
    checkOutput("rst_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("rst_be", {28'd0, dmem_be}, 32'd0);
    checkOutput("rst_addr", dmem_addr, 32'd0);
    checkOutput("rst_wdata", dmem_wdata, 32'd0);
    checkOutput("rst_read", readDataM, 32'd0);
    checkOutput("rst_buserr", {31'd0, busErrM}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
`ifdef MEM_MISALIGN_TRAP_EN
      if (vecs[i].misal) continue;
`endif
      applyStimulus(vecs[i]);
    end

    // Back-to-back: a store presented during the load's DONE cycle.
    memReadM = 1; memWriteM = 0; sizeM = 2'b10; unsignedM = 0;
    ALUOutM = 32'h800; dmem_rdata = 32'h13579BDF;
    @(negedge clk);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    checkOutput("b2b_load", readDataM, 32'h13579BDF);
    checkOutput("b2b_done_stall", {31'd0, stallM}, 32'd0);
    memReadM = 0; memWriteM = 1; ALUOutM = 32'h804; writeDataM = 32'h2468ACE0;
    @(negedge clk);
    checkOutput("b2b_idle_stall", {31'd0, stallM}, 32'd1);
    checkOutput("b2b_idle_req", {31'd0, dmem_req}, 32'd0);
    @(negedge clk);
    checkOutput("b2b_busy_req", {31'd0, dmem_req}, 32'd1);
    checkOutput("b2b_addr", dmem_addr, 32'h804);
    checkOutput("b2b_we", {31'd0, dmem_we}, 32'd1);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    checkOutput("b2b_store_read", readDataM, 32'h13579BDF);
    memWriteM = 0;
    @(negedge clk);

    // Timeout: never acknowledge.
    memReadM = 1; sizeM = 2'b10; ALUOutM = 32'h700;
    req_cnt = 0;
    finished = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dmem_req) req_cnt++;
      if (!stallM) begin
        finished = 1;
        break;
      end
    end
    checkOutput("timeout_reached", {31'd0, finished}, 32'd1);
    checkOutput("timeout_req_cycles", req_cnt, 32'd16);
    checkOutput("timeout_buserr", {31'd0, busErrM}, 32'd1);
    checkOutput("timeout_read", readDataM, 32'd0);
    checkOutput("timeout_req_low", {31'd0, dmem_req}, 32'd0);
    memReadM = 0;
    @(negedge clk);
    checkOutput("buserr_held", {31'd0, busErrM}, 32'd1);
    applyStimulus('{1, 0, 2'b10, 0, 32'h704, 32'h0, 32'h00000005, 1,
                    32'h704, 4'b1111, 32'h0, 0, 32'h00000005, 0});

    // Reset mid-access drops the request without a clock edge.
    memReadM = 1; sizeM = 2'b10; ALUOutM = 32'h900;
    @(negedge clk);
    checkOutput("rstbusy_req_before", {31'd0, dmem_req}, 32'd1);
    #2;
    reset = 1'b1;
    memReadM = 0;
    #1;
    checkOutput("rstbusy_req_after", {31'd0, dmem_req}, 32'd0);
    checkOutput("rstbusy_read", readDataM, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    dmem_rdata = 32'hFFFFFFFF;
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    checkOutput("late_ack_read", readDataM, 32'd0);
    checkOutput("late_ack_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("late_ack_buserr", {31'd0, busErrM}, 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    memReadM = 1; sizeM = 2'b10; ALUOutM = 32'h101;
    #1;
    checkOutput("trap_idle_stall", {31'd0, stallM}, 32'd1);
    @(negedge clk);
    checkOutput("trap_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("trap_misalign", {31'd0, misalignM}, 32'd1);
    checkOutput("trap_read", readDataM, 32'd0);
    checkOutput("trap_done_stall", {31'd0, stallM}, 32'd0);
    memReadM = 0;
    @(negedge clk);
    applyStimulus('{1, 0, 2'b10, 0, 32'h104, 32'h0, 32'h0000CAFE, 1,
                    32'h104, 4'b1111, 32'h0, 0, 32'h0000CAFE, 0});
    checkOutput("trap_cleared", {31'd0, misalignM}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-stage access unit of the 5-stage pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB register; produces the readDataM value that the MEM/WB register captures.
- Converts load/store requests into a req/ack transaction with a variable-latency data memory.
- Handles byte/half/word sizing with sign/zero extension, and holds the pipeline via stallM until the access completes or times out.

Parameters:
- MAX_WAIT, 16: cycles in BUSY without dmem_ack before the access aborts with a bus error; legal range 1..255.
- WAIT_W, 8: width of the wait counter; must satisfy 2**WAIT_W > MAX_WAIT.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- memReadM  in  1  load request from EX/MEM.
- memWriteM  in  1  store request from EX/MEM.
- sizeM  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- unsignedM  in  1  1 = zero-extend loads, 0 = sign-extend.
- ALUOutM  in  32  effective byte address.
- writeDataM  in  32  store data, right-justified.
- dmem_req  out  1  request to data memory; registered.
- dmem_we  out  1  1 = write; registered.
- dmem_addr  out  32  word-aligned address ({ALUOutM[31:2],2'b00}); registered.
- dmem_be  out  4  byte enables; registered.
- dmem_wdata  out  32  lane-replicated store data; registered.
- dmem_ack  in  1  one-cycle completion pulse from memory.
- dmem_rdata  in  32  read word, valid while dmem_ack=1.
- readDataM  out  32  formatted load result; registered.
- stallM  out  1  combinational hold request to the pipeline registers.
- busErrM  out  1  access aborted by timeout; registered; held in DONE.

Behaviour:
- Reset: state IDLE; dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, readDataM, busErrM and the wait counter all 0. Reset asserted mid-access drops dmem_req immediately. A late dmem_ack after reset is ignored.
- access = memReadM | memWriteM. If both are asserted, the access is a store and the read is ignored.
- stallM = access && state != DONE. It is 0 in DONE, so the pipeline advances on that cycle.
- IDLE:
  - No access: stay IDLE.
  - Access: latch dmem_addr/we/be/wdata, set dmem_req=1, clear counter and busErrM, go to BUSY.
- BUSY: dmem_req holds 1 and the request fields hold stable.
  - dmem_ack=1: dmem_req<=0. On a load, readDataM<=formatted dmem_rdata; on a store, readDataM is unchanged. Go to DONE.
  - No ack and counter==MAX_WAIT-1: dmem_req<=0, busErrM<=1, readDataM<=0, go to DONE.
  - Otherwise: counter+1.
- DONE: unconditional return to IDLE next cycle. busErrM is cleared on the next IDLE→BUSY transition.
- Back-to-back accesses: a new access is seen in IDLE the cycle after DONE.
- Minimum latency: 3 cycles per access (IDLE→BUSY→DONE with ack in the first BUSY cycle). stallM is high for 2 of those cycles.
- Store lanes:
  - byte: be = 1<<addr[1:0]; wdata = {4{wd[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011; wdata = {2{wd[15:0]}}.
  - word: be = 1111; wdata = wd.
- Load lanes:
  - byte: lane addr[1:0].
  - half: lane addr[1].
  - Extend to 32 bits per unsignedM.
- Misaligned addresses (half with addr[0]=1; word with addr[1:0]!=0): low address bits are ignored, and lane selection uses the rules above.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalignM (1 bit, registered, reset 0).
  - A misaligned access in IDLE issues no dmem_req and goes directly to DONE with misalignM=1 and readDataM=0. This is a 2-cycle access with stallM high for 1 cycle.
  - misalignM is cleared on the next IDLE→BUSY or IDLE→DONE transition.
- Undefined: no port; misaligned accesses follow the lane rules above.

Decomposition:
- Package mem_stage_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - state enum IDLE/BUSY/DONE.
  - byte-enable constants.
- Sub-module mem_load_align: purely combinational. Inputs: rdata, addr[1:0], size, unsigned. Output: the extended 32-bit load value. Shared with any future uncached/IO path.

Test Plan:
- Word load @0x100, ack after 2 BUSY cycles, rdata 0xDEADBEEF → dmem_req high 2 cycles, be=1111, readDataM=0xDEADBEEF, stallM high 3 cycles.
- Byte load @0x103 signed, rdata 0x80000000 → readDataM=0xFFFFFF80. Same with unsignedM=1 → 0x00000080.
- Half store @0x202, writeDataM 0x0000ABCD → dmem_addr=0x200, be=1100, wdata=0xABCDABCD, readDataM unchanged.
- No ack with MAX_WAIT=16 → dmem_req drops after 16 BUSY cycles, busErrM=1, readDataM=0, stallM released in DONE.
- Reset asserted during BUSY → dmem_req=0 and state IDLE without waiting for a clock; ack 2 cycles later produces no change.
- With MEM_MISALIGN_TRAP_EN: word load @0x101 → no dmem_req, misalignM=1 in DONE, stallM high 1 cycle.
